multicycle_mips: RTL and testbench

Parametrised multi-cycle successor to the team's single-cycle MIPS core, with the same instruction and data memory port set.
- Each instruction runs through an FSM (IF/ID/EX/MEM/WB) with registered datapath state.
- Data memory has a configurable wait-state latency.
- Memory control outputs are registered and glitch-free.
- Sits between the instruction ROM and the synchronous data SRAM in the top-level testbench/system.

---
 rtl/multicycle_mips.sv | 244 ++++++++++++++++++++++++
 tb/tb_multicycle_mips.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_mips.sv
// Multi-cycle MIPS subset core (IF/ID/EX/MEM/WB) with wait-stated data memory.
// Optional perf counters (cycle_cnt, retire_cnt) enabled by MULTICYCLE_MIPS_PERF_EN.
module multicycle_mips #(
  parameter int unsigned DMEM_AW  = 7,
  parameter int unsigned MEM_LAT  = 1,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [31:0]        IR_addr,
  input  logic [31:0]        IR,
  input  logic [31:0]        ReadDataMem,
  output logic               CEN,
  output logic               WEN,
  output logic               OEN,
  output logic [DMEM_AW-1:0] A,
  output logic [31:0]        Data2Mem
`ifdef MULTICYCLE_MIPS_PERF_EN
  ,
  output logic [31:0]        cycle_cnt,
  output logic [31:0]        retire_cnt
`endif
);

  typedef enum logic [2:0] {StIf, StId, StEx, StMem, StWb} state_e;

  localparam logic [3:0] LastWait = 4'(MEM_LAT - 1);

  localparam logic [5:0] OpRtype = 6'h00, OpJ = 6'h02, OpJal = 6'h03, OpBeq = 6'h04;
  localparam logic [5:0] OpBne = 6'h05, OpAddi = 6'h08, OpLw = 6'h23, OpSw = 6'h2b;
  localparam logic [5:0] FnSll = 6'h00, FnSrl = 6'h02, FnJr = 6'h08, FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22, FnAnd = 6'h24, FnOr = 6'h25, FnSlt = 6'h2a;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d, instr_q, instr_d, reg_a_q, reg_a_d, reg_b_q, reg_b_d;
  logic [31:0]        alu_q, alu_d, mdr_q, mdr_d, d2m_q, d2m_d;
  logic [3:0]         wait_q, wait_d;
  logic               cen_q, cen_d, wen_q, wen_d, oen_q, oen_d;
  logic [DMEM_AW-1:0] a_q, a_d;
  logic [31:0]        rf_q [32];
  logic               rf_we;
  logic [4:0]         rf_wa;
  logic [31:0]        rf_wd;

  logic [5:0]  op, fn;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] simm, ea, alu_r;
  logic        legal;

  assign op    = instr_q[31:26];
  assign rs    = instr_q[25:21];
  assign rt    = instr_q[20:16];
  assign rd    = instr_q[15:11];
  assign shamt = instr_q[10:6];
  assign fn    = instr_q[5:0];
  assign simm  = {{16{instr_q[15]}}, instr_q[15:0]};
  assign ea    = reg_a_q + simm;
  // Anything outside the supported set retires as a NOP straight from ID.
  assign legal = ((op == OpRtype) &&
                  (fn inside {FnSll, FnSrl, FnJr, FnAdd, FnSub, FnAnd, FnOr, FnSlt})) ||
                 (op inside {OpBeq, OpBne, OpAddi, OpLw, OpSw});

  // R-type ALU result from the operands latched in ID
  always_comb begin
    alu_r = '0;
    case (fn)
      FnAdd:   alu_r = reg_a_q + reg_b_q;
      FnSub:   alu_r = reg_a_q - reg_b_q;
      FnAnd:   alu_r = reg_a_q & reg_b_q;
      FnOr:    alu_r = reg_a_q | reg_b_q;
      FnSlt:   alu_r = {31'b0, $signed(reg_a_q) < $signed(reg_b_q)};
      FnSll:   alu_r = reg_b_q << shamt;
      FnSrl:   alu_r = reg_b_q >> shamt;
      default: alu_r = '0;
    endcase
  end

  // Next-state, datapath and memory-control decode
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    reg_a_d = reg_a_q;
    reg_b_d = reg_b_q;
    alu_d   = alu_q;
    mdr_d   = mdr_q;
    d2m_d   = d2m_q;
    wait_d  = wait_q;
    cen_d   = cen_q;
    wen_d   = wen_q;
    oen_d   = oen_q;
    a_d     = a_q;
    rf_we   = 1'b0;
    rf_wa   = '0;
    rf_wd   = '0;
    case (state_q)
      StIf: begin
        instr_d = IR;
        pc_d    = pc_q + 32'd4;
        state_d = StId;
      end
      StId: begin
        reg_a_d = rf_q[rs];
        reg_b_d = rf_q[rt];
        if (op == OpJ || op == OpJal) begin
          pc_d    = {pc_q[31:28], instr_q[25:0], 2'b00};
          state_d = StIf;
          if (op == OpJal) begin
            rf_we = 1'b1;
            rf_wa = 5'd31;
            rf_wd = pc_q;
          end
        end else begin
          state_d = legal ? StEx : StIf;
        end
      end
      StEx: begin
        state_d = StIf;
        case (op)
          OpRtype: begin
            if (fn == FnJr) begin
              pc_d = reg_a_q;
            end else begin
              alu_d   = alu_r;
              state_d = StWb;
            end
          end
          OpAddi: begin
            alu_d   = ea;
            state_d = StWb;
          end
          OpBeq: if (reg_a_q == reg_b_q) pc_d = pc_q + {simm[29:0], 2'b00};
          OpBne: if (reg_a_q != reg_b_q) pc_d = pc_q + {simm[29:0], 2'b00};
          OpLw, OpSw: begin
            alu_d   = ea;
            a_d     = ea[DMEM_AW+1:2];
            cen_d   = 1'b0;
            oen_d   = (op != OpLw);
            wen_d   = (op != OpSw);
            wait_d  = '0;
            state_d = StMem;
            if (op == OpSw) d2m_d = reg_b_q;
          end
          default: state_d = StIf;
        endcase
      end
      StMem: begin
        if (wait_q == LastWait) begin
          cen_d = 1'b1;
          wen_d = 1'b1;
          oen_d = 1'b1;
          if (op == OpLw) begin
            mdr_d   = ReadDataMem;
            state_d = StWb;
          end else begin
            state_d = StIf;
          end
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      StWb: begin
        rf_we   = 1'b1;
        state_d = StIf;
        if (op == OpRtype) begin
          rf_wa = rd;
          rf_wd = alu_q;
        end else begin
          rf_wa = rt;
          rf_wd = (op == OpLw) ? mdr_q : alu_q;
        end
      end
      default: state_d = StIf;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIf;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      reg_a_q <= '0;
      reg_b_q <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
      d2m_q   <= '0;
      wait_q  <= '0;
      cen_q   <= 1'b1;
      wen_q   <= 1'b1;
      oen_q   <= 1'b1;
      a_q     <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      reg_a_q <= reg_a_d;
      reg_b_q <= reg_b_d;
      alu_q   <= alu_d;
      mdr_q   <= mdr_d;
      d2m_q   <= d2m_d;
      wait_q  <= wait_d;
      cen_q   <= cen_d;
      wen_q   <= wen_d;
      oen_q   <= oen_d;
      a_q     <= a_d;
    end
  end

  // Register file; $0 is never written so it always reads zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (rf_we && rf_wa != 5'd0) begin
      rf_q[rf_wa] <= rf_wd;
    end
  end

`ifdef MULTICYCLE_MIPS_PERF_EN
  logic [31:0] cycle_q, retire_q;

  // IF always advances to ID, so any entry into IF marks a retirement
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q  <= '0;
      retire_q <= '0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (state_q != StIf && state_d == StIf) retire_q <= retire_q + 32'd1;
    end
  end

  assign cycle_cnt  = cycle_q;
  assign retire_cnt = retire_q;
`endif

  assign IR_addr  = pc_q;
  assign CEN      = cen_q;
  assign WEN      = wen_q;
  assign OEN      = oen_q;
  assign A        = a_q;
  assign Data2Mem = d2m_q;

endmodule

// File: tb/tb_multicycle_mips.sv
// Self-checking bench for multicycle_mips: an instruction-level ISA model runs in
// lockstep with the core and predicts fetch addresses, latencies and memory traffic.
module tb_multicycle_mips;
  localparam int unsigned DMEM_AW  = 7;
  localparam int unsigned MEM_LAT  = 3;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam int unsigned Words    = 1 << DMEM_AW;
  localparam logic [31:0] NopWord  = 32'hFC00_0000;  // opcode 0x3F, unsupported

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [31:0]        IR_addr, IR, ReadDataMem, Data2Mem;
  logic               CEN, WEN, OEN;
  logic [DMEM_AW-1:0] A;
`ifdef MULTICYCLE_MIPS_PERF_EN
  logic [31:0]        cycle_cnt, retire_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] rom [256];
  logic [31:0] sram [Words] = '{default: 32'h0};
  int          rd_cnt = 0;

  // ISA-level reference state
  logic [31:0] m_rf [32];
  logic [31:0] m_mem [Words] = '{default: 32'h0};
  logic [31:0] m_pc;
  int unsigned m_cycles, m_retired;

  multicycle_mips #(
    .DMEM_AW (DMEM_AW),
    .MEM_LAT (MEM_LAT),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .IR_addr    (IR_addr),
    .IR         (IR),
    .ReadDataMem(ReadDataMem),
    .CEN        (CEN),
    .WEN        (WEN),
    .OEN        (OEN),
    .A          (A),
    .Data2Mem   (Data2Mem)
`ifdef MULTICYCLE_MIPS_PERF_EN
    ,
    .cycle_cnt  (cycle_cnt),
    .retire_cnt (retire_cnt)
`endif
  );

  always #5 clk = ~clk;

  assign IR = rom[IR_addr[9:2]];
  // Read data is only valid on the last wait-state cycle; junk otherwise.
  assign ReadDataMem = (!CEN && !OEN && rd_cnt == MEM_LAT - 1) ? sram[A] : 32'hBAD0_0BAD;

  always @(posedge clk) begin
    if (!CEN && !WEN) sram[A] <= Data2Mem;
    rd_cnt <= CEN ? 0 : rd_cnt + 1;
  end

  function automatic logic [31:0] enc_r(input int fn, input int rs, input int rt,
                                        input int rd, input int sh);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] enc_j(input int op, input int addr);
    return {6'(op), 26'(addr)};
  endfunction

  task automatic m_wr(input logic [4:0] dst, input logic [31:0] val);
    if (dst != 5'd0) m_rf[dst] = val;
  endtask

  // Execute one instruction architecturally; report its latency and memory access.
  task automatic model_step(input logic [31:0] ins, output int lat, output int kind,
                            output logic [DMEM_AW-1:0] maddr, output logic [31:0] mdata);
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sh;
    logic [31:0] a, b, simm, nxt, ea;
    op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16];
    rd = ins[15:11]; sh = ins[10:6];  fn = ins[5:0];
    a = m_rf[rs]; b = m_rf[rt];
    simm = 32'($signed(ins[15:0]));
    ea = a + simm;
    nxt = m_pc + 32'd4;
    lat = 2; kind = 0; maddr = '0; mdata = '0;
    case (op)
      6'h00: begin
        lat = 4;
        case (fn)
          6'h20: m_wr(rd, a + b);
          6'h22: m_wr(rd, a - b);
          6'h24: m_wr(rd, a & b);
          6'h25: m_wr(rd, a | b);
          6'h2a: m_wr(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
          6'h00: m_wr(rd, b << sh);
          6'h02: m_wr(rd, b >> sh);
          6'h08: begin lat = 3; nxt = a; end
          default: lat = 2;
        endcase
      end
      6'h08: begin lat = 4; m_wr(rt, ea); end
      6'h23: begin
        lat = 4 + MEM_LAT; kind = 2; maddr = DMEM_AW'(ea / 4);
        m_wr(rt, m_mem[maddr]);
      end
      6'h2b: begin
        lat = 3 + MEM_LAT; kind = 1; maddr = DMEM_AW'(ea / 4); mdata = b;
        m_mem[maddr] = b;
      end
      6'h04: begin lat = 3; if (a == b) nxt = nxt + simm * 4; end
      6'h05: begin lat = 3; if (a != b) nxt = nxt + simm * 4; end
      6'h02: nxt = {nxt[31:28], ins[25:0], 2'b00};
      6'h03: begin m_wr(5'd31, m_pc + 32'd4); nxt = {nxt[31:28], ins[25:0], 2'b00}; end
      default: lat = 2;
    endcase
    m_pc = nxt;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = NopWord;
  endtask

  // Reset the core and the model; returns just after a rising edge with the core in IF.
  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_pc = RESET_PC;
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_cycles = 0;
    m_retired = 0;
  endtask

  // Lockstep n instructions: fetch address, latency and per-cycle memory handshake.
  task automatic run_instrs(input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0]        pc0, ins, mdata;
      logic [DMEM_AW-1:0] maddr;
      int                 lat, kind, bad_ctl, bad_mem;
      logic               in_mem;
      logic [2:0]         exp_ctl, last_ctl, last_exp;
      pc0 = m_pc;
      ins = rom[m_pc[9:2]];
      model_step(ins, lat, kind, maddr, mdata);
      m_cycles += lat;
      m_retired++;
      bad_ctl = 0; bad_mem = 0; last_ctl = 3'b111; last_exp = 3'b111;
      for (int c = 0; c < lat; c++) begin
        @(negedge clk);
        if (c == 0) begin
          n_checks++;
          if (IR_addr !== pc0) begin
            n_fail++;
            $display("FAIL fetch_addr instr %08h: IR_addr=%08h expected %08h", ins, IR_addr, pc0);
          end
        end
        in_mem  = (kind != 0) && (c >= 3) && (c < 3 + MEM_LAT);
        exp_ctl = {!in_mem, !(in_mem && kind == 1), !(in_mem && kind == 2)};
        if ({CEN, WEN, OEN} !== exp_ctl) begin
          bad_ctl++; last_ctl = {CEN, WEN, OEN}; last_exp = exp_ctl;
        end
        if (in_mem && (A !== maddr || (kind == 1 && Data2Mem !== mdata))) bad_mem++;
        @(posedge clk);
      end
      n_checks++;
      if (bad_ctl != 0) begin
        n_fail++;
        $display("FAIL mem_ctl instr %08h at %08h: %0d bad cycles, CEN/WEN/OEN=%b expected %b",
                 ins, pc0, bad_ctl, last_ctl, last_exp);
      end
      if (kind != 0) begin
        n_checks++;
        if (bad_mem != 0) begin
          n_fail++;
          $display("FAIL mem_addr_data instr %08h: A=%0h Data2Mem=%08h expected A=%0h data=%08h",
                   ins, A, Data2Mem, maddr, mdata);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    n_checks++;
    if (IR_addr !== RESET_PC) begin
      n_fail++; $display("FAIL reset_pc: IR_addr=%08h expected %08h", IR_addr, RESET_PC);
    end
    n_checks++;
    if ({CEN, WEN, OEN} !== 3'b111) begin
      n_fail++; $display("FAIL reset_ctl: CEN/WEN/OEN=%b expected 111", {CEN, WEN, OEN});
    end
    n_checks++;
    if (A !== '0 || Data2Mem !== 32'h0) begin
      n_fail++; $display("FAIL reset_bus: A=%0h Data2Mem=%08h expected 0 0", A, Data2Mem);
    end
`ifdef MULTICYCLE_MIPS_PERF_EN
    n_checks++;
    if (cycle_cnt !== 32'h0 || retire_cnt !== 32'h0) begin
      n_fail++; $display("FAIL reset_perf: cycle=%0d retire=%0d expected 0 0", cycle_cnt, retire_cnt);
    end
`endif
  endtask

  task automatic test_alu();
    clear_rom();
    rom[0] = enc_i(8, 0, 1, 5);
    rom[1] = enc_i(8, 0, 2, -3);
    rom[2] = enc_r(6'h20, 1, 2, 3, 0);
    rom[3] = enc_i(6'h2b, 0, 3, 0);
    do_reset();
    run_instrs(4);
    #1;
    n_checks++;
    if (sram[0] !== 32'd2) begin
      n_fail++; $display("FAIL alu_add: stored $3=%08h expected 00000002", sram[0]);
    end
  endtask

  task automatic test_mem();
    clear_rom();
    rom[0] = enc_i(8, 0, 1, 16'h10);
    rom[1] = enc_i(8, 0, 2, 16'hDEAD);
    rom[2] = enc_r(6'h00, 0, 2, 2, 16);
    rom[3] = enc_i(8, 2, 2, 16'h7EEF);
    rom[4] = enc_i(8, 2, 2, 16'h4000);
    rom[5] = enc_i(6'h2b, 1, 2, 4);
    rom[6] = enc_i(6'h23, 1, 4, 4);
    rom[7] = enc_i(6'h2b, 0, 4, 8);
    do_reset();
    run_instrs(8);
    #1;
    n_checks++;
    if (sram[5] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL sw_word5: sram[5]=%08h expected deadbeef", sram[5]);
    end
    n_checks++;
    if (sram[2] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL lw_result: stored $4=%08h expected deadbeef", sram[2]);
    end
  endtask

  task automatic test_branch();
    clear_rom();
    rom[0] = enc_j(2, 8);
    rom[8] = enc_i(4, 0, 0, -1);
    do_reset();
    run_instrs(5);
    clear_rom();
    rom[0] = enc_j(2, 9);
    rom[9] = enc_i(5, 0, 0, 8);
    do_reset();
    run_instrs(2);
    #1;
    n_checks++;
    if (IR_addr !== 32'h28) begin
      n_fail++; $display("FAIL bne_not_taken: IR_addr=%08h expected 00000028", IR_addr);
    end
    run_instrs(1);
  endtask

  task automatic test_jump();
    clear_rom();
    rom[0]  = enc_j(2, 32'h40);
    rom[64] = enc_j(3, 32'h40);
    rom[65] = enc_i(6'h2b, 0, 31, 12);
    do_reset();
    run_instrs(2);
    #1;
    n_checks++;
    if (IR_addr !== 32'h100) begin
      n_fail++; $display("FAIL jal_target: IR_addr=%08h expected 00000100", IR_addr);
    end
    rom[64] = enc_r(6'h08, 31, 0, 0, 0);
    run_instrs(2);
    #1;
    n_checks++;
    if (sram[3] !== 32'h104) begin
      n_fail++; $display("FAIL jal_link: stored $31=%08h expected 00000104", sram[3]);
    end
  endtask

  task automatic test_nop_slt();
    clear_rom();
    rom[0] = enc_i(8, 0, 0, 7);
    rom[1] = enc_i(8, 0, 1, 5);
    rom[2] = enc_i(8, 0, 2, -3);
    rom[3] = enc_r(6'h2a, 2, 1, 5, 0);
    rom[4] = NopWord;
    rom[5] = enc_i(6'h2b, 0, 0, 16);
    rom[6] = enc_i(6'h2b, 0, 5, 20);
    do_reset();
    run_instrs(7);
    #1;
    n_checks++;
    if (sram[4] !== 32'h0) begin
      n_fail++; $display("FAIL zero_reg: stored $0=%08h expected 00000000", sram[4]);
    end
    n_checks++;
    if (sram[5] !== 32'h1) begin
      n_fail++; $display("FAIL slt_signed: stored $5=%08h expected 00000001", sram[5]);
    end
  endtask

  function automatic logic [31:0] rand_instr();
    int k;
    int fns [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00, 6'h02};
    int rs, rt, rd;
    k = $urandom_range(0, 99);
    rs = $urandom_range(0, 7); rt = $urandom_range(0, 7); rd = $urandom_range(0, 7);
    if (k < 40)      return enc_r(fns[$urandom_range(0, 6)], rs, rt, rd, $urandom_range(0, 31));
    else if (k < 55) return enc_i(8, rs, rt, $urandom_range(0, 65535));
    else if (k < 67) return enc_i(6'h2b, rs, rt, $urandom_range(0, 65535));
    else if (k < 79) return enc_i(6'h23, rs, rt, $urandom_range(0, 65535));
    else if (k < 86) return enc_i(4, rs, rt, $urandom_range(0, 16) - 8);
    else if (k < 91) return enc_i(5, rs, rt, $urandom_range(0, 16) - 8);
    else if (k < 94) return enc_j(2, $urandom_range(0, 255));
    else if (k < 96) return enc_j(3, $urandom_range(0, 255));
    else if (k < 97) return enc_r(6'h08, rs, 0, 0, 0);
    else if (k < 99) return enc_r(6'h3f, rs, rt, rd, 0);
    return NopWord;
  endfunction

  task automatic test_random();
    int bad;
    for (int i = 0; i < 256; i++) rom[i] = rand_instr();
    do_reset();
    run_instrs(300);
    #1;
    bad = 0;
    for (int w = 0; w < Words; w++) if (sram[w] !== m_mem[w]) bad++;
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL random_sram: %0d words differ from model, expected 0", bad);
    end
`ifdef MULTICYCLE_MIPS_PERF_EN
    n_checks++;
    if (cycle_cnt !== m_cycles) begin
      n_fail++; $display("FAIL perf_cycles: cycle_cnt=%0d expected %0d", cycle_cnt, m_cycles);
    end
    n_checks++;
    if (retire_cnt !== m_retired) begin
      n_fail++; $display("FAIL perf_retire: retire_cnt=%0d expected %0d", retire_cnt, m_retired);
    end
`endif
  endtask

  task automatic test_reset_mid_mem();
    clear_rom();
    rom[0] = enc_i(6'h23, 0, 7, 20);
    rom[1] = enc_i(6'h2b, 0, 7, 24);
    do_reset();
    // Cycles 0..2 are IF/ID/EX; cycle 4 is the second wait-state cycle.
    for (int c = 0; c < 5; c++) @(negedge clk);
    n_checks++;
    if ({CEN, OEN} !== 2'b00) begin
      n_fail++; $display("FAIL mid_mem_active: CEN/OEN=%b expected 00", {CEN, OEN});
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({CEN, WEN, OEN} !== 3'b111) begin
      n_fail++; $display("FAIL async_release: CEN/WEN/OEN=%b expected 111", {CEN, WEN, OEN});
    end
    n_checks++;
    if (IR_addr !== RESET_PC) begin
      n_fail++; $display("FAIL async_pc: IR_addr=%08h expected %08h", IR_addr, RESET_PC);
    end
`ifdef MULTICYCLE_MIPS_PERF_EN
    n_checks++;
    if (cycle_cnt !== 32'h0 || retire_cnt !== 32'h0) begin
      n_fail++; $display("FAIL async_perf: cycle=%0d retire=%0d expected 0 0", cycle_cnt, retire_cnt);
    end
`endif
    do_reset();
    run_instrs(2);
    #1;
    n_checks++;
    if (sram[6] !== m_mem[5]) begin
      n_fail++; $display("FAIL restart_lw_sw: sram[6]=%08h expected %08h", sram[6], m_mem[5]);
    end
  endtask

  initial begin
    clear_rom();
    test_reset();
    test_alu();
    test_mem();
    test_branch();
    test_jump();
    test_nop_slt();
    test_random();
    test_reset_mid_mem();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
